sine_playback_ctrl: RTL and testbench

Sequencer for the 1024-entry sine lookup table. It turns start/stop commands and a small configuration register set into paced LUT reads, then presents each sample downstream on a valid/ready handshake. The block sits between the configuration/control source and the LUT memory, and feeds the sample consumer (7-segment hex display path or DAC).

---
 rtl/sine_playback_ctrl.sv | 169 ++++++++++++++++
 tb/tb_sine_playback_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sine_playback_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : sine_playback_ctrl
// Brief   : Paces sine-LUT reads and presents samples on a valid/ready port.
// Rev     : 1.0
// ============================================================================
module sine_playback_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_addr,
  input  logic [15:0]       cfg_wdata,
  input  logic              start,
  input  logic              stop,
  output logic              lut_rd,
  output logic [ADDR_W-1:0] lut_addr,
  input  logic [DATA_W-1:0] lut_data,
  output logic [DATA_W-1:0] sample_out,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_TICK = 3'd1,
    FETCH     = 3'd2,
    CAPTURE   = 3'd3,
    PRESENT   = 3'd4
  } state_t;

  localparam logic [DIV_W-1:0]  DIV_RST  = DIV_W'(4);
  localparam logic [DIV_W-1:0]  DIV_MIN  = DIV_W'(2);
  localparam logic [ADDR_W-1:0] STEP_RST = ADDR_W'(1);

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [DIV_W-1:0]  tick_cnt_q, tick_cnt_d;
  logic [ADDR_W-1:0] step_q, step_d;
  logic [ADDR_W-1:0] phase_q, phase_d;
  logic [15:0]       burst_q, burst_d;
  logic [15:0]       count_q, count_d;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic              done_q, done_d;
  logic              overrun_q, overrun_d;

  logic              active;
  logic              tick;
  logic [DIV_W-1:0]  div_wr;
  logic              burst_end;

  assign active    = (state_q != IDLE);
  assign tick      = active && (tick_cnt_q == '0);
  assign div_wr    = DIV_W'(cfg_wdata);
  assign burst_end = (burst_q != 16'd0) && (count_q == burst_q);

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    tick_cnt_d = tick_cnt_q;
    step_d     = step_q;
    phase_d    = phase_q;
    burst_d    = burst_q;
    count_d    = count_q;
    sample_d   = sample_q;
    done_d     = 1'b0;
    overrun_d  = overrun_q;

    // Free-running pacing counter while active: one tick per DIV+1 cycles.
    if (active) begin
      tick_cnt_d = tick ? div_q : (tick_cnt_q - DIV_W'(1));
    end

    case (state_q)
      IDLE: begin
        if (cfg_we) begin
          case (cfg_addr)
            2'd0:    div_d   = (div_wr < DIV_MIN) ? DIV_MIN : div_wr;
            2'd1:    step_d  = ADDR_W'(cfg_wdata);
            2'd2:    burst_d = cfg_wdata;
            default: ;
          endcase
        end
        if (start && !stop) begin
          phase_d    = '0;
          count_d    = '0;
          overrun_d  = 1'b0;
          tick_cnt_d = div_q;
          state_d    = WAIT_TICK;
        end
      end
      WAIT_TICK: begin
        if (tick) state_d = FETCH;
      end
      FETCH: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        sample_d = lut_data;
        phase_d  = phase_q + step_q;
        count_d  = count_q + 16'd1;
        state_d  = PRESENT;
      end
      PRESENT: begin
        if (sample_ready) begin
          if (burst_end) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else if (tick) begin
            state_d = FETCH;
          end else begin
            state_d = WAIT_TICK;
          end
        end else if (tick) begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort beats everything, including a completing handshake.
    if (active && stop) begin
      state_d = IDLE;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      div_q      <= DIV_RST;
      tick_cnt_q <= '0;
      step_q     <= STEP_RST;
      phase_q    <= '0;
      burst_q    <= '0;
      count_q    <= '0;
      sample_q   <= '0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      tick_cnt_q <= tick_cnt_d;
      step_q     <= step_d;
      phase_q    <= phase_d;
      burst_q    <= burst_d;
      count_q    <= count_d;
      sample_q   <= sample_d;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
    end
  end

  assign lut_rd       = (state_q == FETCH);
  assign lut_addr     = phase_q;
  assign sample_out   = sample_q;
  assign sample_valid = (state_q == PRESENT);
  assign busy         = active;
  assign done         = done_q;
  assign overrun      = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_sine_playback_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_sine_playback_ctrl
// Brief   : Directed vector table plus hand sequences for sine_playback_ctrl.
// Rev     : 1.0
// ============================================================================
module tb_sine_playback_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_addr = 2'd0;
  logic [15:0] cfg_wdata = 16'd0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        lut_rd;
  logic [9:0]  lut_addr;
  logic [15:0] lut_data = 16'd0;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic        sample_ready = 1'b0;
  logic        busy;
  logic        done;
  logic        overrun;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int rd_cnt = 0;

  sine_playback_ctrl #(.ADDR_W(10), .DATA_W(16), .DIV_W(16)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .start(start), .stop(stop), .lut_rd(lut_rd),
    .lut_addr(lut_addr), .lut_data(lut_data), .sample_out(sample_out),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .busy(busy),
    .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lut_fn(input logic [9:0] a);
    return {a[5:0], a} ^ 16'hA55A;
  endfunction

  // Synchronous-read LUT model: data valid the cycle after lut_rd.
  always @(posedge clk) begin
    if (lut_rd) lut_data <= lut_fn(lut_addr);
    if (done) done_cnt <= done_cnt + 1;
    if (lut_rd) rd_cnt <= rd_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_rd(input int bound);
    int n = 0;
    while (lut_rd !== 1'b1 && n < bound) begin
      step();
      n++;
    end
    chk("wait lut_rd", 32'(lut_rd), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1; cfg_we = 1'b0; start = 1'b0; stop = 1'b0; sample_ready = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [15:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; step(); stop = 1'b0;
  endtask

  typedef struct {
    logic [15:0] div_w;
    logic [15:0] step_w;
    logic [15:0] burst_w;
    logic [9:0]  a0, a1, a2;
    int          lat;
    int          per;
  } vec_t;

  vec_t vecs [6];

  task automatic run_vec(input vec_t v, input int idx);
    logic [9:0] ea [3];
    int t_prev, d0, r0;
    ea[0] = v.a0; ea[1] = v.a1; ea[2] = v.a2;
    do_reset();
    cfg_write(2'd0, v.div_w);
    cfg_write(2'd1, v.step_w);
    cfg_write(2'd2, v.burst_w);
    sample_ready = 1'b1;
    d0 = done_cnt;
    pulse_start();
    t_prev = cyc;
    for (int k = 0; k < 3; k++) begin
      wait_rd(40);
      chk($sformatf("v%0d rd%0d addr", idx, k), 32'(lut_addr), 32'(ea[k]));
      chk($sformatf("v%0d rd%0d spacing", idx, k), 32'(cyc - t_prev),
          32'((k == 0) ? v.lat : v.per));
      t_prev = cyc;
      step(); step();
      chk($sformatf("v%0d s%0d valid", idx, k), 32'(sample_valid), 32'd1);
      chk($sformatf("v%0d s%0d data", idx, k), 32'(sample_out), 32'(lut_fn(ea[k])));
    end
    chk($sformatf("v%0d overrun", idx), 32'(overrun), 32'd0);
    if (v.burst_w != 16'd0) begin
      step();
      chk($sformatf("v%0d done", idx), 32'(done), 32'd1);
      chk($sformatf("v%0d busy after done", idx), 32'(busy), 32'd0);
      chk($sformatf("v%0d valid at done", idx), 32'(sample_valid), 32'd0);
      r0 = rd_cnt;
      repeat (20) step();
      chk($sformatf("v%0d extra reads", idx), 32'(rd_cnt - r0), 32'd0);
      chk($sformatf("v%0d done pulses", idx), 32'(done_cnt - d0), 32'd1);
    end else begin
      chk($sformatf("v%0d busy", idx), 32'(busy), 32'd1);
      pulse_stop();
      chk($sformatf("v%0d busy after stop", idx), 32'(busy), 32'd0);
      chk($sformatf("v%0d valid after stop", idx), 32'(sample_valid), 32'd0);
      chk($sformatf("v%0d no done", idx), 32'(done_cnt - d0), 32'd0);
    end
  endtask

  initial begin
    logic [9:0] exp_a;
    int t_prev, d0, r0, rd_seen;

    //            div      step      burst  a0     a1       a2       lat per
    vecs[0] = '{16'd4, 16'd1,    16'd0, 10'd0, 10'd1,    10'd2,    5,  5};
    vecs[1] = '{16'd1, 16'd7,    16'd3, 10'd0, 10'd7,    10'd14,   3,  3};
    vecs[2] = '{16'd9, 16'd1020, 16'd0, 10'd0, 10'd1020, 10'd1016, 10, 10};
    vecs[3] = '{16'd3, 16'd513,  16'd3, 10'd0, 10'd513,  10'd2,    4,  4};
    vecs[4] = '{16'd0, 16'd0,    16'd0, 10'd0, 10'd0,    10'd0,    3,  3};
    vecs[5] = '{16'd5, 16'hFC01, 16'd0, 10'd0, 10'd1,    10'd2,    6,  6};

    // Reset state
    rst = 1'b1;
    step(); step();
    chk("rst lut_rd", 32'(lut_rd), 32'd0);
    chk("rst lut_addr", 32'(lut_addr), 32'd0);
    chk("rst sample_out", 32'(sample_out), 32'd0);
    chk("rst sample_valid", 32'(sample_valid), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst overrun", 32'(overrun), 32'd0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Phase wrap across 1030 samples with STEP=1, DIV=2
    do_reset();
    cfg_write(2'd0, 16'd2);
    sample_ready = 1'b1;
    pulse_start();
    exp_a = 10'd0;
    for (int i = 0; i < 1030; i++) begin
      wait_rd(10);
      chk($sformatf("wrap rd%0d addr", i), 32'(lut_addr), 32'(exp_a));
      step(); step();
      chk($sformatf("wrap s%0d data", i), 32'(sample_out), 32'(lut_fn(exp_a)));
      exp_a = exp_a + 10'd1;
    end
    pulse_stop();

    // Overrun: consumer stalls through several ticks
    do_reset();
    cfg_write(2'd0, 16'd2);
    sample_ready = 1'b0;
    pulse_start();
    wait_rd(10);
    step(); step();
    chk("ovr first valid", 32'(sample_valid), 32'd1);
    rd_seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (lut_rd) rd_seen++;
    end
    chk("ovr reads while stalled", 32'(rd_seen), 32'd0);
    chk("ovr flag", 32'(overrun), 32'd1);
    chk("ovr still valid", 32'(sample_valid), 32'd1);
    sample_ready = 1'b1;
    wait_rd(10);
    chk("ovr resume addr", 32'(lut_addr), 32'd1);
    chk("ovr sticky", 32'(overrun), 32'd1);
    pulse_stop();
    pulse_start();
    chk("ovr cleared by start", 32'(overrun), 32'd0);
    chk("ovr busy after restart", 32'(busy), 32'd1);
    pulse_stop();

    // Config writes while busy are ignored
    do_reset();
    sample_ready = 1'b1;
    d0 = done_cnt;
    pulse_start();
    cfg_write(2'd1, 16'd5);
    cfg_write(2'd2, 16'd1);
    for (int k = 0; k < 3; k++) begin
      wait_rd(20);
      chk($sformatf("busycfg rd%0d addr", k), 32'(lut_addr), 32'(k));
      step();
    end
    chk("busycfg no done", 32'(done_cnt - d0), 32'd0);
    pulse_stop();

    // Stop while presenting
    do_reset();
    sample_ready = 1'b0;
    pulse_start();
    wait_rd(20);
    step(); step();
    chk("stop pre valid", 32'(sample_valid), 32'd1);
    d0 = done_cnt;
    pulse_stop();
    chk("stop busy", 32'(busy), 32'd0);
    chk("stop valid", 32'(sample_valid), 32'd0);
    chk("stop done", 32'(done), 32'd0);
    r0 = rd_cnt;
    repeat (15) step();
    chk("stop no reads", 32'(rd_cnt - r0), 32'd0);
    chk("stop no done pulse", 32'(done_cnt - d0), 32'd0);

    // start and stop together from IDLE
    do_reset();
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    chk("start+stop busy", 32'(busy), 32'd0);
    r0 = rd_cnt;
    repeat (12) step();
    chk("start+stop no reads", 32'(rd_cnt - r0), 32'd0);

    // Reset mid-run restores outputs and config defaults
    do_reset();
    cfg_write(2'd0, 16'd9);
    cfg_write(2'd1, 16'd7);
    cfg_write(2'd2, 16'd5);
    pulse_start();
    wait_rd(20);
    sample_ready = 1'b1;
    wait_rd(20);
    sample_ready = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    chk("mid rst lut_rd", 32'(lut_rd), 32'd0);
    chk("mid rst lut_addr", 32'(lut_addr), 32'd0);
    chk("mid rst sample_out", 32'(sample_out), 32'd0);
    chk("mid rst valid", 32'(sample_valid), 32'd0);
    chk("mid rst busy", 32'(busy), 32'd0);
    chk("mid rst done", 32'(done), 32'd0);
    chk("mid rst overrun", 32'(overrun), 32'd0);
    rst = 1'b0;
    sample_ready = 1'b1;
    d0 = done_cnt;
    pulse_start();
    t_prev = cyc;
    for (int k = 0; k < 7; k++) begin
      wait_rd(20);
      chk($sformatf("post rst rd%0d addr", k), 32'(lut_addr), 32'(k));
      chk($sformatf("post rst rd%0d spacing", k), 32'(cyc - t_prev), 32'd5);
      t_prev = cyc;
      step();
    end
    chk("post rst no burst done", 32'(done_cnt - d0), 32'd0);
    chk("post rst busy", 32'(busy), 32'd1);
    pulse_stop();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
